uart_tx: RTL and testbench

Serial transmitter for the UART IP, sitting directly downstream of the TX `fifo`. It:
- pops one word at a time from the FIFO whenever the FIFO is non-empty and transmission is enabled;
- serialises the word LSB-first onto the line as start bit, data bits, optional parity bit and stop bit(s);
- uses a per-bit clock-cycle counter for timing;
- reports busy and frame-done status to the register interface.

---
 rtl/uart_tx.sv | 193 +++++++++++++++++++
 tb/tb_uart_tx.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// UART serial transmitter: fetches words from the TX FIFO and sends start, data (LSB first), parity, stop.
// Optional even-parity bit is enabled with the UART_TX_PARITY_EN macro.
`timescale 1ns/1ps

module uart_tx #(
    parameter int SIZE_DATA    = 8,
    parameter int CLKS_PER_BIT = 434,
    parameter int STOP_BITS    = 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_tx_en,
    input  logic                 i_fifo_empty,
    input  logic [SIZE_DATA-1:0] i_fifo_data,
    output logic                 o_fifo_rd_en,
    output logic                 o_tx,
    output logic                 o_busy,
    output logic                 o_tx_done
);

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W  = $clog2(SIZE_DATA + 1);

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(SIZE_DATA - 1);
    localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_LOAD   = 3'd2,
        ST_START  = 3'd3,
        ST_DATA   = 3'd4,
        ST_PARITY = 3'd5,
        ST_STOP   = 3'd6
    } state_t;

    state_t               state_r, state_s;
    logic [SIZE_DATA-1:0] shift_r, shift_s;
    logic [BIT_W-1:0]     bit_cnt_r, bit_cnt_s;
    logic [BAUD_W-1:0]    baud_r, baud_s;
    logic                 bit_end_s;
    logic                 tx_s, busy_s, rd_en_s, done_s;
    logic                 tx_r, busy_r, rd_en_r, done_r;
`ifdef UART_TX_PARITY_EN
    logic                 parity_r, parity_s;

    function automatic logic even_parity(input logic [SIZE_DATA-1:0] d);
        return ^d;
    endfunction
`endif

    assign bit_end_s = (baud_r == BAUD_LAST);

    // State, datapath and registered-output flops.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r   <= ST_IDLE;
            shift_r   <= '0;
            bit_cnt_r <= '0;
            baud_r    <= '0;
            tx_r      <= 1'b1;
            busy_r    <= 1'b0;
            rd_en_r   <= 1'b0;
            done_r    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_r  <= 1'b0;
`endif
        end else begin
            state_r   <= state_s;
            shift_r   <= shift_s;
            bit_cnt_r <= bit_cnt_s;
            baud_r    <= baud_s;
            tx_r      <= tx_s;
            busy_r    <= busy_s;
            rd_en_r   <= rd_en_s;
            done_r    <= done_s;
`ifdef UART_TX_PARITY_EN
            parity_r  <= parity_s;
`endif
        end
    end

    // Next-state and datapath updates; the bit counter is reused to count stop bits.
    always_comb begin
        state_s   = state_r;
        shift_s   = shift_r;
        bit_cnt_s = bit_cnt_r;
        baud_s    = baud_r;
`ifdef UART_TX_PARITY_EN
        parity_s  = parity_r;
`endif
        case (state_r)
            ST_IDLE: begin
                if (i_tx_en && !i_fifo_empty) begin
                    state_s = ST_FETCH;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_FETCH: begin
                state_s = ST_LOAD;
            end
            ST_LOAD: begin
                shift_s   = i_fifo_data;
                bit_cnt_s = '0;
                baud_s    = '0;
`ifdef UART_TX_PARITY_EN
                parity_s  = even_parity(i_fifo_data);
`endif
                state_s   = ST_START;
            end
            ST_START: begin
                if (bit_end_s) begin
                    baud_s  = '0;
                    state_s = ST_DATA;
                end else begin
                    baud_s  = baud_r + BAUD_W'(1);
                end
            end
            ST_DATA: begin
                if (bit_end_s) begin
                    baud_s  = '0;
                    shift_s = shift_r >> 1;
                    if (bit_cnt_r == DATA_LAST) begin
                        bit_cnt_s = '0;
`ifdef UART_TX_PARITY_EN
                        state_s   = ST_PARITY;
`else
                        state_s   = ST_STOP;
`endif
                    end else begin
                        bit_cnt_s = bit_cnt_r + BIT_W'(1);
                    end
                end else begin
                    baud_s = baud_r + BAUD_W'(1);
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (bit_end_s) begin
                    baud_s  = '0;
                    state_s = ST_STOP;
                end else begin
                    baud_s  = baud_r + BAUD_W'(1);
                end
            end
`endif
            ST_STOP: begin
                if (bit_end_s) begin
                    baud_s = '0;
                    if (bit_cnt_r == STOP_LAST) begin
                        bit_cnt_s = '0;
                        state_s   = ST_IDLE;
                    end else begin
                        bit_cnt_s = bit_cnt_r + BIT_W'(1);
                    end
                end else begin
                    baud_s = baud_r + BAUD_W'(1);
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Output values decoded from the upcoming state so the registered outputs line up with it.
    always_comb begin
        tx_s    = 1'b1;
        busy_s  = (state_s != ST_IDLE);
        rd_en_s = (state_s == ST_FETCH);
        done_s  = 1'b0;
        case (state_s)
            ST_START: tx_s = 1'b0;
            ST_DATA:  tx_s = shift_s[0];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: tx_s = parity_s;
`endif
            ST_STOP: begin
                tx_s   = 1'b1;
                done_s = (baud_s == BAUD_LAST) && (bit_cnt_s == STOP_LAST);
            end
            default: tx_s = 1'b1;
        endcase
    end

    assign o_tx         = tx_r;
    assign o_busy       = busy_r;
    assign o_fifo_rd_en = rd_en_r;
    assign o_tx_done    = done_r;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx with a behavioural FIFO and a bit-level frame model.
`timescale 1ns/1ps

module tb_uart_tx;

    localparam int C     = 4;
    localparam int STOPB = 1;
`ifdef UART_TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int FRAME = (1 + 8 + P + STOPB) * C;

    typedef struct {
        logic [7:0] data;
        logic       par;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tx_en = 1'b0;
    logic       fifo_empty = 1'b1;
    logic [7:0] fifo_data = 8'h00;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       fifo_rd_en, tx, busy, tx_done;
    logic [7:0] fifo_q[$];
    int         total = 0;
    int         bad = 0;
    time        last_rd_t = 0;

    always #5 clk = ~clk;

    uart_tx #(.SIZE_DATA(8), .CLKS_PER_BIT(C), .STOP_BITS(STOPB)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_tx_en      (tx_en),
        .i_fifo_empty (fifo_empty),
        .i_fifo_data  (fifo_data),
        .o_fifo_rd_en (fifo_rd_en),
        .o_tx         (tx),
        .o_busy       (busy),
        .o_tx_done    (tx_done)
    );

    // Behavioural FIFO: registered read data and registered empty flag.
    always @(posedge clk) begin
        if (wr_en) fifo_q.push_back(wr_data);
        if (fifo_rd_en && fifo_q.size() > 0) fifo_data <= fifo_q.pop_front();
        fifo_empty <= (fifo_q.size() == 0);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    task automatic check(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    // Expected line level at cycle i of a frame: start, LSB-first data, parity, stop.
    function automatic logic exp_level(input logic [7:0] d, input logic par, input int i);
        int b;
        b = i / C;
        if (b == 0) return 1'b0;
        else if (b <= 8) return d[b-1];
        else if (P == 1 && b == 9) return par;
        else return 1'b1;
    endfunction

    task automatic push(input logic [7:0] d);
        wr_data = d;
        wr_en   = 1'b1;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    task automatic wait_rd(input int max_wait, output bit seen);
        seen = 1'b0;
        for (int w = 0; w < max_wait; w++) begin
            @(negedge clk);
            if (fifo_rd_en) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic check_frame(input logic [7:0] d, input logic par, input int max_wait,
                               input int drop_at, input int gap, input string tag);
        bit seen;
        int lvl_bad, done_bad, busy_bad;
        lvl_bad = 0; done_bad = 0; busy_bad = 0;
        wait_rd(max_wait, seen);
        check({tag, ".fetch"}, int'(seen), 1);
        if (!seen) return;
        if (gap > 0) check({tag, ".gap"}, int'(($time - last_rd_t) / 10), gap);
        last_rd_t = $time;
        @(negedge clk);
        check({tag, ".pulse"}, int'({fifo_rd_en, tx}), 1);
        for (int i = 0; i < FRAME; i++) begin
            @(negedge clk);
            if (i == drop_at) tx_en = 1'b0;
            if (tx !== exp_level(d, par, i)) lvl_bad++;
            if (tx_done !== (i == FRAME - 1)) done_bad++;
            if (busy !== 1'b1) busy_bad++;
        end
        check({tag, ".level"}, lvl_bad, 0);
        check({tag, ".done"}, done_bad, 0);
        check({tag, ".busy"}, busy_bad, 0);
        @(negedge clk);
        check({tag, ".idle"}, int'({busy, tx_done, tx}), 1);
    endtask

    initial begin
        vec_t       tbl[7];
        bit         seen;
        int         cnt;
        int         n;
        logic [7:0] d;
        logic [7:0] sb[$];

        tbl[0] = '{8'hA5, 1'b0};
        tbl[1] = '{8'h07, 1'b1};
        tbl[2] = '{8'h00, 1'b0};
        tbl[3] = '{8'hFF, 1'b0};
        tbl[4] = '{8'h55, 1'b0};
        tbl[5] = '{8'h80, 1'b1};
        tbl[6] = '{8'h3C, 1'b0};

        repeat (3) @(negedge clk);
        check("rst.tx", int'(tx), 1);
        check("rst.busy", int'(busy), 0);
        check("rst.rd_en", int'(fifo_rd_en), 0);
        check("rst.done", int'(tx_done), 0);

        rst_n = 1'b1;
        tx_en = 1'b1;
        cnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (fifo_rd_en) cnt++;
        end
        check("empty.no_rd", cnt, 0);

        for (int v = 0; v < 7; v++) begin
            push(tbl[v].data);
            check_frame(tbl[v].data, tbl[v].par, 4, -1, 0, $sformatf("vec%0d", v));
        end

        tx_en = 1'b0;
        push(8'h00);
        push(8'hFF);
        push(8'h55);
        tx_en = 1'b1;
        check_frame(8'h00, 1'b0, 4, -1, 0, "b2b0");
        check_frame(8'hFF, 1'b0, 2, -1, FRAME + 3, "b2b1");
        check_frame(8'h55, 1'b0, 2, -1, FRAME + 3, "b2b2");
        cnt = 0;
        repeat (30) begin
            @(negedge clk);
            if (fifo_rd_en) cnt++;
        end
        check("b2b.no_rd", cnt, 0);
        check("b2b.empty", int'(fifo_empty), 1);

        tx_en = 1'b0;
        push(8'h3C);
        push(8'hC3);
        tx_en = 1'b1;
        check_frame(8'h3C, 1'b0, 4, 3 * C, 0, "gate0");
        cnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (fifo_rd_en) cnt++;
        end
        check("gate.held", cnt, 0);
        tx_en = 1'b1;
        check_frame(8'hC3, 1'b0, 2, -1, 0, "gate1");

        tx_en = 1'b0;
        push(8'hF0);
        push(8'h81);
        tx_en = 1'b1;
        wait_rd(4, seen);
        check("mrst.fetch", int'(seen), 1);
        repeat (18) @(negedge clk);
        check("mrst.bit3", int'({busy, tx}), 2);
        #2 rst_n = 1'b0;
        #1;
        check("mrst.async", int'({busy, tx, fifo_rd_en, tx_done}), 4);
        @(negedge clk);
        rst_n = 1'b1;
        check_frame(8'h81, 1'b0, 2, -1, 0, "mrst.next");

        for (int b = 0; b < 5; b++) begin
            n = $urandom_range(4, 1);
            tx_en = 1'b0;
            for (int k = 0; k < n; k++) begin
                d = 8'($urandom);
                sb.push_back(d);
                push(d);
            end
            tx_en = 1'b1;
            for (int k = 0; k < n; k++) begin
                d = sb.pop_front();
                check_frame(d, ^d, (k == 0) ? 4 : 2, -1, (k == 0) ? 0 : FRAME + 3,
                            $sformatf("rnd%0d_%0d", b, k));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
